// File: rtl/shift_seq_32.sv
// rtl/shift_seq_32.sv - iterative one-bit-per-clock 32-bit shift/rotate unit
//
// Performs shr, shra, shl, ror and rol one bit position per clock under a
// start/busy/done handshake. Opcodes 101-111 and amount 0 complete at once
// with z = a.
//
// Ports:
//   clock   in   rising-edge clock
//   clear   in   asynchronous active-low reset
//   start   in   request, accepted in IDLE or DONE
//   op      in   3-bit operation select
//   a       in   operand, sampled with start
//   amount  in   shift amount 0..31, sampled with start
//   busy    out  high while iterating (registered)
//   done    out  one-cycle completion pulse (registered)
//   z       out  result register, updated only on entry to DONE

module shift_seq_32 #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] step_val;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic [2:0] o);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SHR:  r = {1'b0, v[WIDTH-1:1]};
            OP_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-2:0], 1'b0};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // start is only honoured when not iterating; in DONE this gives back-to-back issue
    assign accept   = start && (state_q != S_RUN);
    assign step_val = step(acc_q, op_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        z_d     = z_q;

        if (accept) begin
            acc_d = a;
            cnt_d = amount;
            op_d  = op;
            if ((amount != '0) && (op <= OP_ROL)) begin
                state_d = S_RUN;
            end else begin
                // nothing to iterate: complete immediately with the operand
                state_d = S_DONE;
                z_d     = a;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_d = step_val;
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = S_DONE;
                        z_d     = step_val;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // outputs are registered copies of the next-state decode
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;

endmodule
